// File: rtl/seven_seg_display_driver_if.sv
// Capture bus carrying the CPU debug value and its strobes into the
// display driver.
interface seven_seg_display_driver_if;
    logic [15:0] value_in;
    logic        value_valid;
    logic        hold;
    logic [3:0]  dp_mask;

    modport master (
        output value_in,
        output value_valid,
        output hold,
        output dp_mask
    );

    modport slave (
        input value_in,
        input value_valid,
        input hold,
        input dp_mask
    );
endinterface

// File: rtl/seven_seg_display_driver.sv
// Multiplexed common-anode 4-digit hex display driver with a
// BLANK/SHOW scan FSM and optional leading-zero suppression.
module seven_seg_display_driver #(
    parameter int SCAN_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit LZ_BLANK     = 1'b0
) (
    input  logic                        clock,
    input  logic                        reset,
    seven_seg_display_driver_if.slave   cap,
    output logic [3:0]                  an,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic                        digit_tick
);
    localparam int MAXC = (SCAN_CYCLES > BLANK_CYCLES) ?
                          SCAN_CYCLES : BLANK_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    nib_q, nib_d;
    logic          dpb_q, dpb_d;
    logic          lz_q, lz_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        disp_d = disp_q;
        if (cap.value_valid && !cap.hold) begin
            disp_d = cap.value_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        nib_d   = nib_q;
        dpb_d   = dpb_q;
        lz_d    = lz_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    nib_d   = disp_q[{idx_q, 2'b00} +: 4];
                    dpb_d   = cap.dp_mask[idx_q];
                    lz_d    = LZ_BLANK && (idx_q != 2'd0) &&
                              ((disp_q >> {idx_q, 2'b00}) == 16'h0);
                end
            end
            default: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    tick_d  = 1'b1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (state_d == ST_SHOW) begin
            an_d = ~(4'b0001 << idx_d);
            if (!lz_d) begin
                seg_d = hex7(nib_d);
                dp_d  = ~dpb_d;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            disp_q  <= 16'h0000;
            nib_q   <= 4'h0;
            dpb_q   <= 1'b0;
            lz_q    <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            nib_q   <= nib_d;
            dpb_q   <= dpb_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_tick = tick_q;
endmodule
